// File: rtl/seq_sqrt_div.sv
// Iterative restoring square root / fixed-point divider sharing one shift/remainder datapath.
// One result bit per CALC cycle, a single ROUND cycle, then a one-cycle DONE pulse.
module seq_sqrt_div #(
  parameter int W = 16,
  parameter int F = W / 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             mode,
  input  logic [W-1:0]     dat_a,
  input  logic [W/2-1:0]   dat_b,
  output logic [W+F-1:0]   result,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam int H  = W / 2;
  localparam int RW = H + 1;       // holds sqrt remainder (<= 2r) and divide remainder (< divisor)
  localparam int SW = W + F + 1;   // dividend/radicand shifter, includes the guard position
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t          state, state_next;
  logic            op_mode, op_mode_next;
  logic [H-1:0]    divisor, divisor_next;
  logic [SW-1:0]   shifter, shifter_next;
  logic [SW-1:0]   quot, quot_next;
  logic [RW-1:0]   rem, rem_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [W+F-1:0]  result_next;
  logic            dz_next;

  logic [H+2:0]    sq_tmp, sq_trial;
  logic [RW-1:0]   dv_tmp, dv_sub;
  logic [H-1:0]    root;
  logic            sq_up;
  logic [W+F-1:0]  sq_res, dv_res;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    sq_tmp   = {rem, shifter[SW-1:SW-2]};
    sq_trial = {1'b0, quot[H-1:0], 2'b01};
    dv_tmp   = {rem[H-1:0], shifter[SW-1]};
    dv_sub   = {1'b0, divisor};
    root     = quot[H-1:0];
    // Round up only when the remainder shows the true root is past r+0.5, and r+1 still fits.
    sq_up    = (rem > {1'b0, root}) && (root != {H{1'b1}});
    sq_res   = {{(W+F-H){1'b0}}, root + {{(H-1){1'b0}}, sq_up}};
    dv_res   = quot[SW-1:1] + {{(W+F-1){1'b0}}, quot[0]};
  end

  always_comb begin
    state_next   = state;
    op_mode_next = op_mode;
    divisor_next = divisor;
    shifter_next = shifter;
    quot_next    = quot;
    rem_next     = rem;
    cnt_next     = cnt;
    result_next  = result;
    dz_next      = dz;
    case (state)
      IDLE: begin
        if (start) begin
          op_mode_next = mode;
          divisor_next = dat_b;
          shifter_next = {dat_a, {(F+1){1'b0}}};
          quot_next    = '0;
          rem_next     = '0;
          if (mode && (dat_b == '0)) begin
            cnt_next    = '0;
            result_next = '1;
            dz_next     = 1'b1;
            state_next  = DONE;
          end else begin
            cnt_next   = mode ? CW'(SW) : CW'(H);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (op_mode) begin
          shifter_next = {shifter[SW-2:0], 1'b0};
          if (dv_tmp >= dv_sub) begin
            rem_next  = dv_tmp - dv_sub;
            quot_next = {quot[SW-2:0], 1'b1};
          end else begin
            rem_next  = dv_tmp;
            quot_next = {quot[SW-2:0], 1'b0};
          end
        end else begin
          shifter_next = {shifter[SW-3:0], 2'b00};
          if (sq_tmp >= sq_trial) begin
            rem_next  = RW'(sq_tmp - sq_trial);
            quot_next = {quot[SW-2:0], 1'b1};
          end else begin
            rem_next  = RW'(sq_tmp);
            quot_next = {quot[SW-2:0], 1'b0};
          end
        end
        cnt_next = cnt - 1'b1;
        if (cnt == CW'(1)) state_next = ROUND;
      end
      ROUND: begin
        result_next = op_mode ? dv_res : sq_res;
        dz_next     = 1'b0;
        state_next  = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      op_mode <= 1'b0;
      divisor <= '0;
      shifter <= '0;
      quot    <= '0;
      rem     <= '0;
      cnt     <= '0;
      result  <= '0;
      dz      <= 1'b0;
    end else begin
      state   <= state_next;
      op_mode <= op_mode_next;
      divisor <= divisor_next;
      shifter <= shifter_next;
      quot    <= quot_next;
      rem     <= rem_next;
      cnt     <= cnt_next;
      result  <= result_next;
      dz      <= dz_next;
    end
  end

endmodule

// File: tb/tb_seq_sqrt_div.sv
// Self-checking bench for seq_sqrt_div at W=16, F=8: directed corner cases plus random ops
// compared against an arithmetic model of rounded sqrt and rounded fixed-point division.
module tb_seq_sqrt_div;
  localparam int W = 16;
  localparam int F = 8;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            start;
  logic            mode;
  logic [W-1:0]    dat_a;
  logic [W/2-1:0]  dat_b;
  logic [W+F-1:0]  result;
  logic            dz, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seq_sqrt_div #(.W(W), .F(F)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .mode(mode),
    .dat_a(dat_a), .dat_b(dat_b), .result(result), .dz(dz),
    .busy(busy), .done(done)
  );

  function automatic logic [W+F-1:0] ref_sqrt(input logic [W-1:0] a);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(a)) r++;
    if ((int'(a) - r * r > r) && (r != (1 << (W/2)) - 1)) r++;
    return (W+F)'(r);
  endfunction

  function automatic logic [W+F-1:0] ref_div(input logic [W-1:0] a, input logic [W/2-1:0] b);
    longint q2;
    if (b == 0) return '1;
    q2 = (longint'(a) << (F + 1)) / longint'(b);
    return (W+F)'((q2 + 1) >> 1);
  endfunction

  function automatic int ref_lat(input logic m, input logic [W/2-1:0] b);
    if (!m) return W/2 + 2;
    if (b == 0) return 1;
    return W + F + 3;
  endfunction

  // Drive one request; lat = edges from capture to the first edge at which done is sampled high.
  task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W/2-1:0] b,
                        output int lat);
    @(negedge CLK);
    mode = m; dat_a = a; dat_b = b; start = 1'b1;
    @(posedge CLK);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic check_op(input string name, input logic m, input logic [W-1:0] a,
                          input logic [W/2-1:0] b);
    int lat;
    logic [W+F-1:0] exp_res;
    exp_res = m ? ref_div(a, b) : ref_sqrt(a);
    run_op(m, a, b, lat);
    checks++;
    if (lat !== ref_lat(m, b)) begin
      errors++;
      $display("FAIL %s latency m=%0d a=%0d b=%0d got %0d want %0d", name, m, a, b, lat, ref_lat(m, b));
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result m=%0d a=%0d b=%0d got %h want %h", name, m, a, b, result, exp_res);
    end
    checks++;
    if (dz !== (m && b == 0)) begin
      errors++;
      $display("FAIL %s dz m=%0d a=%0d b=%0d got %0d want %0d", name, m, a, b, dz, (m && b == 0));
    end
    $display("op %s m=%0d a=%0d b=%0d result=%h dz=%0d lat=%0d", name, m, a, b, result, dz, lat);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; start = 1'b0; mode = 1'b0; dat_a = '0; dat_b = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({busy, done, dz, result} !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%0d done=%0d dz=%0d result=%h want all zero", busy, done, dz, result);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %0d want 0", busy);
    end
  endtask

  task automatic test_vectors;
    check_op("sqrt211", 1'b0, 16'd211, 8'd0);
    check_op("sqrtmax", 1'b0, 16'hFFFF, 8'd0);
    check_op("sqrt0", 1'b0, 16'd0, 8'd0);
    check_op("sqrt1", 1'b0, 16'd1, 8'd0);
    check_op("div2by3", 1'b1, 16'd2, 8'd3);
    check_op("div100by3", 1'b1, 16'd100, 8'd3);
    check_op("divmaxby1", 1'b1, 16'hFFFF, 8'd1);
    check_op("divmaxby255", 1'b1, 16'hFFFF, 8'd255);
  endtask

  task automatic test_div_zero;
    check_op("div5by0", 1'b1, 16'd5, 8'd0);
    check_op("sqrt_after_dz", 1'b0, 16'd49, 8'd0);
  endtask

  task automatic test_done_pulse;
    int lat;
    run_op(1'b0, 16'd1000, 8'd0, lat);
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width done=%0d busy=%0d want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    check_op("b2b_div", 1'b1, 16'd1234, 8'd77);
    check_op("b2b_sqrt", 1'b0, 16'd40000, 8'd9);
    check_op("b2b_div2", 1'b1, 16'd7, 8'd200);
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic [W+F-1:0] first_res = '0;
    int lat = -1;
    @(negedge CLK);
    mode = 1'b0; dat_a = 16'd211; dat_b = 8'd0; start = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      start = (k == 3);
      if (k == 3) begin mode = 1'b1; dat_a = 16'd1000; dat_b = 8'd7; end
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = k; first_res = result; end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignore_start_pulses got %0d want 1", pulses);
    end
    checks++;
    if (first_res !== ref_sqrt(16'd211) || lat != 10) begin
      errors++;
      $display("FAIL ignore_start_result got %h lat %0d want %h lat 10", first_res, lat, ref_sqrt(16'd211));
    end
    $display("op ignore_start pulses=%0d result=%h lat=%0d", pulses, first_res, lat);
  endtask

  task automatic test_mid_reset;
    int pulses = 0;
    @(negedge CLK);
    mode = 1'b1; dat_a = 16'd100; dat_b = 8'd3; start = 1'b1;
    @(posedge CLK);
    repeat (5) @(negedge CLK);
    start = 1'b0;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result !== '0 || done !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async busy=%0d result=%h done=%0d dz=%0d want 0", busy, result, done, dz);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", pulses);
    end
    $display("op mid_reset pulses_after=%0d", pulses);
    check_op("after_reset", 1'b0, 16'd211, 8'd0);
  endtask

  task automatic test_random;
    logic m;
    logic [W-1:0] a;
    logic [W/2-1:0] b;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : (W/2)'($urandom);
      check_op("random", m, a, b);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_div_zero;
    test_done_pulse;
    test_back_to_back;
    test_ignore_start;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
